// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the elastic pipeline stage and its
// performance counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_counter.sv
// Event counter for the performance-monitor bus: optional saturation,
// synchronous clear that wins over increment.
module pipe_perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (!(SATURATE && (count_q == {CNT_W{1'b1}}))) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic valid/ready stage with registered valid, ready and data,
// plus stall and transfer counters.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_hs;
    logic             out_hs;

    // Both handshake qualifiers come from the state register, so neither
    // ready nor valid has a combinational path from the opposite side.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_hs && out_hs) begin
                        main_d = in_data;
                    end else if (in_hs) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    pipe_perf_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    pipe_perf_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b0)
    ) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs),
        .clr   (cnt_clr),
        .count (xfer_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks for pipe_skid_stage with 4-bit counters so
// saturation and wrap are reachable quickly.
module tb_pipe_skid_stage;

    localparam int WIDTH = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] xfer_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_skid_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [63:0] od;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then sample just after it.
    task automatic step(input logic fl, input logic iv, input logic [63:0] d, input logic ordy);
        @(negedge clk);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [63:0] q[$];
    logic [63:0] nxt;
    logic [63:0] exp_d;
    logic        ir0;
    int          outs;
    int          cycles;
    int          stall_m;
    int          xfer_m;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_xfer_cnt", xfer_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream with the consumer always ready.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 64'(i), 1);
            check("stream_out_valid", out_valid, 1);
            check("stream_in_ready", in_ready, 1);
            check("stream_out_data", out_data, 64'(i));
            $display("stream beat %0d: out_data=%0h in_ready=%0b", i, out_data, in_ready);
        end
        step(0, 0, 0, 1);
        check("stream_drain_valid", out_valid, 0);
        check("stream_xfer_cnt", xfer_cnt, 8);

        // Stall with 0xA/0xB/0xC, then release in order.
        tbl[0] = '{0, 1, 64'hA, 0, 1, 1, 64'hA};
        tbl[1] = '{0, 1, 64'hB, 0, 1, 0, 64'hA};
        tbl[2] = '{0, 1, 64'hC, 0, 1, 0, 64'hA};
        tbl[3] = '{0, 1, 64'hC, 1, 1, 1, 64'hB};
        tbl[4] = '{0, 1, 64'hC, 1, 1, 1, 64'hC};
        tbl[5] = '{0, 0, 64'h0, 1, 0, 1, 64'hC};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check("tbl_out_valid", out_valid, tbl[i].ov);
            check("tbl_in_ready", in_ready, tbl[i].ir);
            check("tbl_out_data", out_data, tbl[i].od);
            $display("vector %0d: out_valid=%0b in_ready=%0b out_data=%0h", i, out_valid, in_ready, out_data);
        end
        check("stall_stall_cnt", stall_cnt, 2);
        check("stall_xfer_cnt", xfer_cnt, 11);

        // Flush while FULL with a beat on the input.
        step(0, 1, 64'h11, 0);
        step(0, 1, 64'h12, 0);
        check("pre_flush_in_ready", in_ready, 0);
        step(1, 1, 64'hD, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_keeps_data", out_data, 64'h11);
        step(0, 0, 0, 1);
        check("flush_idle_valid", out_valid, 0);
        step(0, 1, 64'h21, 1);
        check("post_flush_data", out_data, 64'h21);
        step(0, 0, 0, 1);
        check("post_flush_drain", out_valid, 0);

        // Asynchronous reset in the middle of a FULL cycle.
        step(0, 1, 64'h31, 0);
        step(0, 1, 64'h32, 0);
        check("pre_areset_full", in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_in_ready", in_ready, 1);
        check("areset_out_data", out_data, 0);
        check("areset_stall_cnt", stall_cnt, 0);
        check("areset_xfer_cnt", xfer_cnt, 0);
        $display("async reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation, wrap and clear-over-increment on 4-bit counters.
        step(0, 1, 64'h40, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check("stall_saturate", stall_cnt, 15);
        for (int i = 0; i < 17; i++) step(0, 1, 64'(i + 64'h41), 1);
        check("xfer_wrap", xfer_cnt, 1);
        check("stall_held", stall_cnt, 15);
        @(negedge clk);
        cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_xfer", xfer_cnt, 0);
        check("clr_stall", stall_cnt, 0);
        check("clr_drained", out_valid, 0);

        // Random valid/ready against an in-order scoreboard.
        do_reset();
        nxt = 64'h1000; outs = 0; cycles = 0; stall_m = 0; xfer_m = 0;
        while (outs < 10000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = nxt;
            out_ready = 1'b0;
            #1 ir0 = in_ready;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready !== ir0) check("rand_ready_comb", in_ready, ir0);
            if (in_valid && in_ready) begin
                q.push_back(nxt);
                nxt++;
            end
            if (out_valid && out_ready) begin
                exp_d = (q.size() != 0) ? q.pop_front() : 64'hDEAD;
                check("rand_order", out_data, exp_d);
                outs++;
                xfer_m++;
            end
            if (out_valid && !out_ready && stall_m != 15) stall_m++;
        end
        check("rand_budget", outs, 10000);
        @(posedge clk);
        #1;
        check("rand_xfer_cnt", xfer_cnt, 64'(xfer_m % 16));
        check("rand_stall_cnt", stall_cnt, 64'(stall_m));
        $display("random: %0d beats in %0d cycles", outs, cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
